// File: rtl/seq_detector_prog.sv
// Run-time programmable Mealy sequence detector with a saturating match counter.
// Define SEQ_DET_REG_OUT_EN to register the match pulse by one cycle.
module seq_detector_prog #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {FILLING, ARMED} phase_t;

    logic [PAT_W-1:0] history;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] window;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic             step;
    logic             match;
    phase_t           phase;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > PAT_W_L) ? PAT_W_L : l;
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] f);
        return (f >= PAT_W_L) ? PAT_W_L : f + LEN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Armed once fill+1 >= len_r; computed without the len_r-1 underflow.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_r));
        end
        window = {history[PAT_W-2:0], in};
        step   = in_valid & ~load;
        phase  = (({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len_r}) ? ARMED : FILLING;
        match  = step && (len_r != '0) && (phase == ARMED) &&
                 ((window & mask) == (pat_r & mask));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
            pat_r   <= '0;
            len_r   <= '0;
            ovl_r   <= 1'b1;
        end else if (load) begin
            pat_r   <= pattern;
            len_r   <= clamp_len(pat_len);
            ovl_r   <= overlap_en;
            history <= '0;
            fill    <= '0;
        end else if (in_valid) begin
            history <= window;
            // Non-overlapping mode starts collecting a fresh pattern after a hit.
            fill    <= (match && !ovl_r) ? '0 : sat_inc_fill(fill);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (match) begin
            match_cnt <= sat_inc_cnt(match_cnt);
            if (match_cnt >= CNT_MAX - CNT_W'(1)) begin
                cnt_sat <= 1'b1;
            end
        end
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic out_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= 1'b0;
        end else begin
            out_r <= match;
        end
    end

    assign out = out_r;
`else
    assign out = match;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog (default build, combinational match pulse).
module tb_seq_detector_prog;

    logic       clk;
    logic       reset;
    logic       in;
    logic       in_valid;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap_en;
    logic       out;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       out2;
    logic [1:0] cnt2;
    logic       sat2;

    int n_cmp;
    int n_fail;
    int exp_cnt;
    bit exp_q[$];

    seq_detector_prog #(.PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .load(load),
        .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en),
        .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_prog #(.PAT_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .load(load),
        .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en),
        .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        @(negedge clk);
        load = 1'b1; pattern = pat; pat_len = len; overlap_en = ovl;
        in_valid = 1'b1; in = 1'b1;
        #1;
        n_cmp++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_out_forced: out=%b expected 0", out);
        end
        @(posedge clk);
        #1;
        load = 1'b0; in_valid = 1'b0;
    endtask

    task automatic run_stream(input string name, input string bits, input string vld, input string exp);
        bit e;
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            in       = (bits[i] == 8'h31);
            in_valid = (vld.len() == 0) ? 1'b1 : (vld[i] == 8'h31);
            exp_q.push_back(exp[i] == 8'h31);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL %s bit%0d: out=%b expected %b", name, i + 1, out, e);
            end
            if (e) exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (match_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        in = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%b cnt=%0d sat=%b expected 0/0/0", out, match_cnt, cnt_sat);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_len0_cnt: cnt=%0d expected 0", match_cnt);
        end
    endtask

    task automatic test_overlap_101();
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b1);
        run_stream("ovl101", "10101011100101010101", "", "00101010000001010101");
    endtask

    task automatic test_nonoverlap_101();
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b0);
        run_stream("novl101", "10101011100101010101", "", "00100010000001000100");
    endtask

    task automatic test_1011();
        apply_reset();
        do_load(8'b0000_1011, 4'd4, 1'b1);
        run_stream("ovl1011", "1011011", "", "0001001");
        apply_reset();
        do_load(8'b0000_1011, 4'd4, 1'b0);
        run_stream("novl1011", "1011011", "", "0001000");
    endtask

    task automatic test_valid_gaps();
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b1);
        run_stream("gaps", "1010101", "1001001", "0000001");
    endtask

    task automatic test_cnt_sat();
        string bits;
        int    m;
        bits = "10101010101";
        m    = 0;
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b1);
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            in = (bits[i] == 8'h31); in_valid = 1'b1;
            if (i >= 2 && (i % 2) == 0) m++;
            @(posedge clk);
            #1;
            n_cmp++;
            if (cnt2 !== 2'((m > 3) ? 3 : m) || sat2 !== (m >= 3)) begin
                n_fail++;
                $display("FAIL cnt_sat bit%0d: cnt=%0d sat=%b expected %0d/%b",
                         i + 1, cnt2, sat2, (m > 3) ? 3 : m, (m >= 3));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_mid_pattern();
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b1);
        run_stream("pre_load", "10", "", "00");
        do_load(8'b0000_0101, 4'd3, 1'b1);
        run_stream("post_load", "101", "", "001");
    endtask

    task automatic test_len_clamp_and_zero();
        apply_reset();
        do_load(8'b1011_0011, 4'd9, 1'b1);
        run_stream("len9", "1011001110110011", "", "0000000100000001");
        apply_reset();
        do_load(8'b0000_0000, 4'd0, 1'b1);
        run_stream("len0", "00000000", "", "00000000");
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_load(8'b0000_0101, 4'd3, 1'b1);
        run_stream("pre_rst", "1010", "", "0010");
        @(negedge clk);
        in = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: out=%b expected 1", out);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0 || cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: out=%b cnt=%0d sat=%b cnt2=%0d expected 0/0/0/0",
                     out, match_cnt, cnt_sat, cnt2);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_cnt = 0;
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; load = 1'b0;
        pattern = '0; pat_len = '0; overlap_en = 1'b1;
        test_reset();
        test_overlap_101();
        test_nonoverlap_101();
        test_1011();
        test_valid_gaps();
        test_cnt_sat();
        test_load_mid_pattern();
        test_len_clamp_and_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
